// File: rtl/reduce_stream.sv
// Streaming lane-wise reduction: adds a FIFO-buffered partner vector to each host vector,
// with pass-through, saturating/wrapping arithmetic and a sticky overflow flag.
module reduce_stream #(
  parameter int IPREC = 8,
  parameter int OPREC = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_a_valid,
  input  logic                     i_a_reduce,
  input  logic [LANES*OPREC-1:0]   i_a_data,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic [LANES*IPREC-1:0]   i_b_data,
  output logic                     o_b_ready,
  output logic [$clog2(DEPTH):0]   o_b_count,
  input  logic                     i_ovf_clr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*OPREC-1:0]   o_result,
  output logic                     o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Exact sum of a sign-extended host lane and partner lane.
  function automatic logic signed [OPREC:0] lane_sum(input logic signed [OPREC-1:0] a,
                                                     input logic signed [IPREC-1:0] b);
    logic signed [OPREC:0] ax;
    logic signed [OPREC:0] bx;
    ax = {a[OPREC-1], a};
    bx = {{(OPREC+1-IPREC){b[IPREC-1]}}, b};
    return ax + bx;
  endfunction

  function automatic logic lane_ovf(input logic signed [OPREC:0] s);
    return s[OPREC] != s[OPREC-1];
  endfunction

  function automatic logic signed [OPREC-1:0] lane_fit(input logic signed [OPREC:0] s);
    if (SAT != 0 && lane_ovf(s))
      return s[OPREC] ? {1'b1, {(OPREC-1){1'b0}}} : {1'b0, {(OPREC-1){1'b1}}};
    else
      return s[OPREC-1:0];
  endfunction

  logic [LANES*IPREC-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_vld_p1;
  logic [LANES*OPREC-1:0] r_result_p1;
  logic                   r_ovf;

  logic                   w_slot_free;
  logic                   w_fire;
  logic                   w_push;
  logic                   w_pop;
  logic [LANES*IPREC-1:0] w_head;
  logic [LANES*OPREC-1:0] w_result_p0;
  logic                   w_ovf_p0;

  assign o_b_ready   = r_count < FULL;
  assign o_b_count   = r_count;
  assign w_slot_free = !r_vld_p1 || i_ready;
  assign o_a_ready   = w_slot_free && (!i_a_reduce || r_count != '0);
  assign w_fire      = i_a_valid && o_a_ready;
  assign w_pop       = w_fire && i_a_reduce;
  assign w_push      = i_b_valid && o_b_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign o_valid  = r_vld_p1;
  assign o_result = r_result_p1;
  assign o_ovf    = r_ovf;

  // p0: lane arithmetic on the incoming host vector and the FIFO head
  always_comb begin
    w_result_p0 = '0;
    w_ovf_p0    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (i_a_reduce) begin
        w_result_p0[k*OPREC +: OPREC] =
          lane_fit(lane_sum(i_a_data[k*OPREC +: OPREC], w_head[k*IPREC +: IPREC]));
        w_ovf_p0 = w_ovf_p0 |
          lane_ovf(lane_sum(i_a_data[k*OPREC +: OPREC], w_head[k*IPREC +: IPREC]));
      end else begin
        w_result_p0[k*OPREC +: OPREC] = i_a_data[k*OPREC +: OPREC];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_b_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // p1: output register and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_fire) begin
        r_vld_p1    <= 1'b1;
        r_result_p1 <= w_result_p0;
      end else if (i_ready) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_fire && w_ovf_p0)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

endmodule
